// File: rtl/fifo_rd_packer_if.sv
// rtl/fifo_rd_packer_if.sv - FIFO read-side and packed-output signal bundle for fifo_rd_packer
interface fifo_rd_packer_if #(
   parameter int DATA_WIDTH = 3,
   parameter int PACK_NUM   = 4,
   parameter int CNT_WIDTH  = 3
);
   logic                           fifo_empty;
   logic                           fifo_rd_en;
   logic [DATA_WIDTH-1:0]          fifo_rd_data;
   logic                           fifo_rd_vld;
   logic                           flush;
   logic [DATA_WIDTH*PACK_NUM-1:0] out_data;
   logic [CNT_WIDTH-1:0]           out_cnt;
   logic                           out_valid;
   logic                           out_ready;

   // master: the packer itself; slave: the FIFO plus downstream consumer
   modport master (
      input  fifo_empty, fifo_rd_data, fifo_rd_vld, flush, out_ready,
      output fifo_rd_en, out_data, out_cnt, out_valid
   );

   modport slave (
      output fifo_empty, fifo_rd_data, fifo_rd_vld, flush, out_ready,
      input  fifo_rd_en, out_data, out_cnt, out_valid
   );
endinterface

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs PACK_NUM async-FIFO read words into one output word
// Reads are throttled so accumulated plus in-flight words never exceed one pack.
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 3,
   parameter int PACK_NUM   = 4,
   parameter int CNT_WIDTH  = 3
) (
   input  logic             rd_clk,
   input  logic             rst_n,
   fifo_rd_packer_if.master bus
);
   localparam int                 ACC_WIDTH = DATA_WIDTH * PACK_NUM;
   localparam logic [CNT_WIDTH:0] PACK_LIM  = (CNT_WIDTH + 1)'(PACK_NUM);
   localparam logic [CNT_WIDTH-1:0] FULL    = CNT_WIDTH'(PACK_NUM);

   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [CNT_WIDTH-1:0] fill_q, fill_d;
   logic                 pending_q, pending_d;
   logic                 flush_pend_q, flush_pend_d;
   logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
   logic [CNT_WIDTH-1:0] out_cnt_q, out_cnt_d;
   logic                 out_valid_q, out_valid_d;

   logic                 load;
   logic                 capture;
   logic                 rd_en;
   logic [CNT_WIDTH-1:0] fill_eff;
   logic [CNT_WIDTH:0]   committed;

   // A load empties the accumulator this edge, so the read decision may already count it as empty.
   always_comb begin
      load      = ((fill_q == FULL) || (flush_pend_q && !pending_q && (fill_q != '0)))
                  && (!out_valid_q || bus.out_ready);
      capture   = bus.fifo_rd_vld && pending_q;
      fill_eff  = load ? '0 : fill_q;
      committed = {1'b0, fill_eff} + {{CNT_WIDTH{1'b0}}, pending_q};
      rd_en     = rst_n && !bus.fifo_empty && !flush_pend_q && (committed < PACK_LIM);
      pending_d = rd_en;
   end

   always_comb begin
      acc_d        = acc_q;
      fill_d       = fill_q;
      flush_pend_d = flush_pend_q;
      out_data_d   = out_data_q;
      out_cnt_d    = out_cnt_q;
      out_valid_d  = out_valid_q;

      if (load) begin
         out_data_d  = acc_q;
         out_cnt_d   = fill_q;
         out_valid_d = 1'b1;
         acc_d       = '0;
         fill_d      = '0;
      end else begin
         if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
         end
         if (capture) begin
            for (int i = 0; i < PACK_NUM; i++) begin
               if (fill_q == CNT_WIDTH'(i)) begin
                  acc_d[i*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_rd_data;
               end
            end
            fill_d = fill_q + CNT_WIDTH'(1);
         end
      end

      // A flush arriving with a full accumulator rides on the pending full load.
      if (flush_pend_q) begin
         if (load || ((fill_q == '0) && !pending_q)) begin
            flush_pend_d = 1'b0;
         end
      end else if (bus.flush && (fill_q != FULL)) begin
         flush_pend_d = 1'b1;
      end
   end

   always_ff @(posedge rd_clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q        <= '0;
         fill_q       <= '0;
         pending_q    <= 1'b0;
         flush_pend_q <= 1'b0;
         out_data_q   <= '0;
         out_cnt_q    <= '0;
         out_valid_q  <= 1'b0;
      end else begin
         acc_q        <= acc_d;
         fill_q       <= fill_d;
         pending_q    <= pending_d;
         flush_pend_q <= flush_pend_d;
         out_data_q   <= out_data_d;
         out_cnt_q    <= out_cnt_d;
         out_valid_q  <= out_valid_d;
      end
   end

   assign bus.fifo_rd_en = rd_en;
   assign bus.out_data   = out_data_q;
   assign bus.out_cnt    = out_cnt_q;
   assign bus.out_valid  = out_valid_q;
endmodule

// File: doc/fifo_rd_packer.md
FIFO_RD_PACKER -- requirements
Module: fifo_rd_packer

Interface
REQ-001 Parameter DATA_WIDTH, default 3: width of one FIFO word.
REQ-002 Parameter PACK_NUM, default 4: FIFO words per packed output word, range 2 to 2**CNT_WIDTH-1.
REQ-003 Parameter CNT_WIDTH, default 3: width of out_cnt.
REQ-004 Port rd_clk, input, 1: sole clock, rising edge, the async FIFO read-side clock.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Port fifo_empty, input, 1: FIFO empty flag.
REQ-007 Port fifo_rd_en, output, 1: FIFO read request.
REQ-008 Port fifo_rd_data, input, DATA_WIDTH: FIFO read data, valid with fifo_rd_vld.
REQ-009 Port fifo_rd_vld, input, 1: FIFO data valid, one cycle after an accepted fifo_rd_en.
REQ-010 Port flush, input, 1: single-cycle pulse that emits any partial pack.
REQ-011 Port out_data, output, DATA_WIDTH*PACK_NUM: packed word.
REQ-012 Port out_cnt, output, CNT_WIDTH: number of valid FIFO words in out_data.
REQ-013 Port out_valid, output, 1: out_data/out_cnt valid.
REQ-014 Port out_ready, input, 1: downstream accept; a transfer occurs when out_valid && out_ready.

Function
REQ-015 Internal state: accumulator acc (DATA_WIDTH*PACK_NUM), fill count (0..PACK_NUM), pending flag, flush_pend flag, output register.
REQ-016 pending SHALL be the value of fifo_rd_en registered on the previous rd_clk edge.
REQ-017 fifo_rd_en SHALL be combinational: !fifo_empty && !flush_pend && (fill_eff + pending < PACK_NUM), where fill_eff = 0 when a load fires this cycle, else fill.
REQ-018 Invariant: fill + pending <= PACK_NUM at every edge, so no read data is ever dropped.
REQ-019 On fifo_rd_vld && pending: fifo_rd_data is written to acc slot fill, bits [fill*DATA_WIDTH +: DATA_WIDTH], and fill increments by 1.
REQ-020 Slot 0 is the LSB slot, so the first FIFO word occupies out_data[DATA_WIDTH-1:0].
REQ-021 fifo_rd_vld SHALL be ignored when pending=0.
REQ-022 Load condition: (fill==PACK_NUM || (flush_pend && pending==0 && fill>0)) && (!out_valid || out_ready).
REQ-023 On load: out_data <= acc with unfilled slots zero, out_cnt <= fill, out_valid <= 1, fill <= 0, acc <= 0.
REQ-024 No FIFO word arrives in a load cycle, because pending=0 whenever a load is enabled.
REQ-025 If out_valid && out_ready and no load occurs: out_valid <= 0.
REQ-026 While out_valid && !out_ready: out_data and out_cnt SHALL be held stable.
REQ-027 flush pulse SHALL set flush_pend; flush_pend SHALL block new reads.
REQ-028 flush_pend SHALL clear on the partial load, or immediately when fill==0 && pending==0 (no output is produced).
REQ-029 A flush while fill==PACK_NUM SHALL be absorbed by the normal full load.
REQ-030 Flush pulses received while flush_pend=1 SHALL be ignored.
REQ-031 Throughput: with the FIFO non-empty and out_ready=1, the block SHALL sustain PACK_NUM words per PACK_NUM+1 cycles.
REQ-032 fifo_empty rising with pending=1 SHALL still capture the in-flight word.

Reset
REQ-033 On rst_n=0, asynchronously: out_valid=0, out_data=0, out_cnt=0, acc=0, fill=0, pending=0, flush_pend=0, hence fifo_rd_en=0.
REQ-034 Reset mid-pack SHALL discard the partial data and any in-flight word.
REQ-035 After reset release, reads resume on the first edge with fifo_empty=0.

Verification
REQ-036 Stream: FIFO holds words 1,2,3,4,5,6,7,0 (DATA_WIDTH=3, PACK_NUM=4), out_ready=1 -> out_data=12'o4321 with out_cnt=4, then 12'o0765 with out_cnt=4, fifo_rd_en never asserted while fifo_empty=1.
REQ-037 Backpressure: out_ready=0 with 12 words queued -> first pack held stable, acc fills to 4, fifo_rd_en=0; set out_ready=1 -> packs emitted in order with no loss or duplication.
REQ-038 Partial flush: 3 words 5,6,7 then a flush pulse -> out_data=12'o0765, out_cnt=3, then fifo_rd_en reasserts.
REQ-039 Flush with pending: flush in the same cycle as a read request -> the in-flight word is captured and included in the partial pack before the load.
REQ-040 Empty flush: flush with fill=0 and pending=0 -> no out_valid, flush_pend clears the next cycle.
REQ-041 Reset mid-operation: assert rst_n=0 with fill=2 and out_valid=1 -> all outputs 0 immediately; the post-reset stream starts at slot 0.
